window_seq_ctrl: RTL and testbench

Frame-level sequencer for the KSIZE-1 line-buffer chain (shift-tap stages) that feeds the KxK convolution window.
- Accepts the pixel stream and drives the shared shift enable of all line-buffer stages.
- Injects zero-pad shifts at end of frame so the last rows drain.
- Tags every completed window with its centre coordinate and border flags.
- Sits between the pixel source and the line-buffer/window-register datapath.

---
 rtl/window_seq_ctrl_pkg.sv | 28 ++
 rtl/window_seq_ctrl_if.sv | 30 +++
 rtl/window_seq_ctrl_raster_cnt.sv | 39 +++
 rtl/window_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_window_seq_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/window_seq_ctrl_pkg.sv
// rtl/window_seq_ctrl_pkg.sv - shared types and constants for the window sequencer
// Purpose: state encoding, window geometry helpers and border bit positions.
// Contents: state_t, half_of(), latency_of(), BORDER_* indices.
package window_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int half_of(input int ksize);
        return (ksize - 1) / 2;
    endfunction

    // Shifts needed before the window centred on (0,0) is complete.
    function automatic int latency_of(input int img_w, input int ksize);
        return half_of(ksize) * img_w + half_of(ksize);
    endfunction

    // border = {top, bottom, left, right}
    localparam int BORDER_TOP    = 3;
    localparam int BORDER_BOTTOM = 2;
    localparam int BORDER_LEFT   = 1;
    localparam int BORDER_RIGHT  = 0;

endpackage

// File: rtl/window_seq_ctrl_if.sv
// rtl/window_seq_ctrl_if.sv - control and window-tag bundle of the window sequencer
// Purpose: groups frame control, pixel handshake, datapath enables and window tags.
// master: pixel source / frame controller (drives start, abort, ivalid).
// slave : window_seq_ctrl (drives iready, tap_en, pad_en, win_*, border, busy, frame_done).
interface window_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             ivalid;
    logic             iready;
    logic             tap_en;
    logic             pad_en;
    logic             win_valid;
    logic [CNT_W-1:0] win_col;
    logic [CNT_W-1:0] win_row;
    logic [3:0]       border;
    logic             busy;
    logic             frame_done;

    modport master (
        output start, abort, ivalid,
        input  iready, tap_en, pad_en, win_valid, win_col, win_row, border, busy, frame_done
    );

    modport slave (
        input  start, abort, ivalid,
        output iready, tap_en, pad_en, win_valid, win_col, win_row, border, busy, frame_done
    );
endinterface

// File: rtl/window_seq_ctrl_raster_cnt.sv
// rtl/window_seq_ctrl_raster_cnt.sv - raster-order column/row counter
// Purpose: counts positions in raster order, wrapping at W-1 / H-1.
// Ports: clock, reset (async active-low), en (advance), clr (sync clear, wins over en),
//        col, row (current position), last (position is (H-1, W-1)).
module raster_cnt #(
    parameter int W  = 640,
    parameter int H  = 480,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          last
);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(H - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/window_seq_ctrl.sv
// rtl/window_seq_ctrl.sv - frame sequencer for the KxK line-buffer window chain
// Purpose: accepts the pixel stream, drives the shared shift enable, injects zero-pad
//          shifts at end of frame and tags each completed window with its centre.
// Ports: clock, reset (async active-low), bus (window_seq_ctrl_if.slave);
//        overrun_cnt[15:0] only when WINDOW_SEQ_CTRL_OVERRUN_EN is defined.
// Optional: WINDOW_SEQ_CTRL_OVERRUN_EN adds a saturating count of ignored ivalid cycles.
module window_seq_ctrl
    import window_seq_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int KSIZE = 3,
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    window_seq_ctrl_if.slave    bus
`ifdef WINDOW_SEQ_CTRL_OVERRUN_EN
    ,
    output logic [15:0]         overrun_cnt
`endif
);
    localparam int HALF = half_of(KSIZE);
    localparam int D    = latency_of(IMG_W, KSIZE);
    localparam int NW   = $clog2(IMG_W * IMG_H + D + 1);

    localparam logic [CNT_W-1:0] EDGE_LO   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] BOTTOM_HI = CNT_W'(IMG_H - 1 - HALF);
    localparam logic [CNT_W-1:0] RIGHT_HI  = CNT_W'(IMG_W - 1 - HALF);
    localparam logic [NW-1:0]    D_N       = NW'(D);

    state_t           state;
    logic [NW-1:0]    n;
    logic             accept;
    logic             tap;
    logic             win_hit;
    logic             start_go;
    logic             abort_go;
    logic             clr;
    logic [CNT_W-1:0] in_col;
    logic [CNT_W-1:0] in_row;
    logic             in_last;
    logic [CNT_W-1:0] c_col;
    logic [CNT_W-1:0] c_row;
    logic             c_last;
    logic [3:0]       c_border;
    logic             win_valid_q;
    logic [CNT_W-1:0] win_col_q;
    logic [CNT_W-1:0] win_row_q;
    logic [3:0]       border_q;

    // The input position is tracked only for its end-of-frame flag.
    logic             unused_in_pos;
    assign unused_in_pos = ^{in_col, in_row};

    assign accept   = bus.ivalid && (state == ST_RUN);
    assign tap      = accept || (state == ST_FLUSH);
    // A shift completes a window once the chain already holds D earlier samples.
    assign win_hit  = tap && (n >= D_N);
    assign start_go = bus.start && (state == ST_IDLE);
    assign abort_go = bus.abort && (state != ST_IDLE);
    assign clr      = start_go || abort_go;

    assign bus.iready     = (state == ST_RUN);
    assign bus.tap_en     = tap;
    assign bus.pad_en     = (state == ST_FLUSH);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.frame_done = (state == ST_DONE);
    assign bus.win_valid  = win_valid_q;
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;
    assign bus.border     = border_q;

    raster_cnt #(.W(IMG_W), .H(IMG_H), .CW(CNT_W)) u_in_pos (
        .clock (clock),
        .reset (reset),
        .en    (accept),
        .clr   (clr),
        .col   (in_col),
        .row   (in_row),
        .last  (in_last)
    );

    raster_cnt #(.W(IMG_W), .H(IMG_H), .CW(CNT_W)) u_centre_pos (
        .clock (clock),
        .reset (reset),
        .en    (win_hit),
        .clr   (clr),
        .col   (c_col),
        .row   (c_row),
        .last  (c_last)
    );

    always_comb begin
        c_border                = '0;
        c_border[BORDER_TOP]    = (c_row < EDGE_LO);
        c_border[BORDER_BOTTOM] = (c_row > BOTTOM_HI);
        c_border[BORDER_LEFT]   = (c_col < EDGE_LO);
        c_border[BORDER_RIGHT]  = (c_col > RIGHT_HI);
    end

    // Frame FSM. Abort overrides every transition, including the last accept
    // and the last flush shift. The flush ends on the shift that emits the
    // final window, which is exactly D shifts after the last accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (abort_go) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.start) state <= ST_RUN;
                ST_RUN:   if (accept && in_last) state <= ST_FLUSH;
                ST_FLUSH: if (win_hit && c_last) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n <= '0;
        end else if (clr) begin
            n <= '0;
        end else if (tap) begin
            n <= n + 1'b1;
        end
    end

    // Window tags are registered so they line up with the line-buffer outputs
    // written on the same edge as the completing shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            border_q    <= '0;
        end else if (abort_go) begin
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            border_q    <= '0;
        end else if (win_hit) begin
            win_valid_q <= 1'b1;
            win_col_q   <= c_col;
            win_row_q   <= c_row;
            border_q    <= c_border;
        end else begin
            win_valid_q <= 1'b0;
        end
    end

`ifdef WINDOW_SEQ_CTRL_OVERRUN_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (start_go) begin
            overrun_cnt <= '0;
        end else if (bus.ivalid && !bus.iready && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_seq_ctrl.sv
// tb/tb_window_seq_ctrl.sv - self-checking bench for window_seq_ctrl
module tb_window_seq_ctrl;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int K     = 3;
    localparam int HF    = (K - 1) / 2;
    localparam int D     = HF * W + HF;
    localparam int NPIX  = W * H;

    logic clock = 1'b0;
    logic reset = 1'b0;

    window_seq_ctrl_if #(.CNT_W(16)) bus ();

`ifdef WINDOW_SEQ_CTRL_OVERRUN_EN
    logic [15:0] overrun_cnt;
`endif

    window_seq_ctrl #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef WINDOW_SEQ_CTRL_OVERRUN_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: frame progress expressed as counts of accepts, pad
    // shifts, total shifts and windows emitted.
    bit in_frame;
    int acc, fl, shifts, wins;
    bit m_wv;
    int m_col, m_row;
    int m_ovr;
    int fr_wins, fr_dones;

    typedef struct {
        int mode;          // 0: ivalid always, 1: alternate, 2: random
        bit start_noise;   // random start pulses while busy
        int abort_at;      // abort once this many accepts are done, -1 none
        int exp_wins;
        int exp_dones;
    } frame_t;

    typedef struct {
        int row;
        int col;
        logic [3:0] border;
    } bvec_t;

    frame_t tbl[5];
    bvec_t  btbl[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_border(input int row, input int col);
        return {row < HF, row > H - 1 - HF, col < HF, col > W - 1 - HF};
    endfunction

    task automatic model_reset();
        in_frame = 0; acc = 0; fl = 0; shifts = 0; wins = 0;
        m_wv = 0; m_col = 0; m_row = 0; m_ovr = 0;
    endtask

    // Called at posedge+1: drive inputs, check mid-cycle, advance the model,
    // then return at the next posedge+1.
    task automatic cycle(input bit iv, input bit st, input bit ab);
        bit e_ir, e_pad, e_done, e_tap;
        bus.ivalid = iv;
        bus.start  = st;
        bus.abort  = ab;
        #2;
        e_ir   = in_frame && (acc < NPIX);
        e_pad  = in_frame && (acc == NPIX) && (fl < D);
        e_done = in_frame && (acc == NPIX) && (fl == D);
        e_tap  = (iv && e_ir) || e_pad;
        chk("iready", 32'(bus.iready), 32'(e_ir));
        chk("pad_en", 32'(bus.pad_en), 32'(e_pad));
        chk("tap_en", 32'(bus.tap_en), 32'(e_tap));
        chk("busy", 32'(bus.busy), 32'(in_frame));
        chk("frame_done", 32'(bus.frame_done), 32'(e_done));
        chk("win_valid", 32'(bus.win_valid), 32'(m_wv));
        if (m_wv) begin
            chk("win_col", 32'(bus.win_col), 32'(m_col));
            chk("win_row", 32'(bus.win_row), 32'(m_row));
            chk("border", 32'(bus.border), 32'(exp_border(m_row, m_col)));
            for (int i = 0; i < 3; i++)
                if (btbl[i].row == m_row && btbl[i].col == m_col)
                    chk("border_tbl", 32'(bus.border), 32'(btbl[i].border));
        end
`ifdef WINDOW_SEQ_CTRL_OVERRUN_EN
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
`endif
        if (bus.win_valid === 1'b1) fr_wins++;
        if (bus.frame_done === 1'b1) fr_dones++;

        if (iv && !e_ir && m_ovr < 65535) m_ovr++;
        if (ab && in_frame) begin
            in_frame = 0; acc = 0; fl = 0; shifts = 0; wins = 0;
            m_wv = 0;
        end else if (!in_frame) begin
            m_wv = 0;
            if (st) begin
                in_frame = 1; acc = 0; fl = 0; shifts = 0; wins = 0;
                m_ovr = 0;
            end
        end else begin
            m_wv = 0;
            if (e_tap) begin
                if (shifts >= D) begin
                    m_wv  = 1;
                    m_col = wins % W;
                    m_row = wins / W;
                    wins++;
                end
                shifts++;
            end
            if (iv && e_ir) acc++;
            if (e_pad) fl++;
            if (e_done) in_frame = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input frame_t f);
        int cyc;
        bit iv, st, ab;
        cyc = 0;
        fr_wins = 0;
        fr_dones = 0;
        cycle(1'b0, 1'b1, 1'b0);
        while (in_frame && cyc < 400) begin
            case (f.mode)
                0:       iv = 1'b1;
                1:       iv = cyc[0];
                default: iv = 1'($urandom_range(0, 1));
            endcase
            st = f.start_noise && ($urandom_range(0, 3) == 0);
            ab = (f.abort_at >= 0) && (acc == f.abort_at);
            cycle(iv, st, ab);
            cyc++;
        end
        chk("frame_timeout", 32'(in_frame), 32'd0);
        repeat (3) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("win_count", 32'(fr_wins), 32'(f.exp_wins));
        chk("done_count", 32'(fr_dones), 32'(f.exp_dones));
    endtask

    initial begin
        tbl[0] = '{mode: 0, start_noise: 0, abort_at: -1, exp_wins: 32, exp_dones: 1};
        tbl[1] = '{mode: 1, start_noise: 0, abort_at: -1, exp_wins: 32, exp_dones: 1};
        tbl[2] = '{mode: 0, start_noise: 0, abort_at: 12, exp_wins: 3,  exp_dones: 0};
        tbl[3] = '{mode: 0, start_noise: 0, abort_at: -1, exp_wins: 32, exp_dones: 1};
        tbl[4] = '{mode: 2, start_noise: 1, abort_at: -1, exp_wins: 32, exp_dones: 1};
        btbl[0] = '{row: 0, col: 0, border: 4'b1010};
        btbl[1] = '{row: 3, col: 7, border: 4'b0101};
        btbl[2] = '{row: 1, col: 3, border: 4'b0000};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ivalid = 1'b0;
        model_reset();

        // Reset held: every output low even with ivalid asserted.
        #7;
        bus.ivalid = 1'b1;
        #1;
        chk("rst_iready", 32'(bus.iready), 32'd0);
        chk("rst_tap_en", 32'(bus.tap_en), 32'd0);
        chk("rst_pad_en", 32'(bus.pad_en), 32'd0);
        chk("rst_win_valid", 32'(bus.win_valid), 32'd0);
        chk("rst_win_col", 32'(bus.win_col), 32'd0);
        chk("rst_win_row", 32'(bus.win_row), 32'd0);
        chk("rst_border", 32'(bus.border), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        bus.ivalid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Released without start: stays idle.
        repeat (8) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Asynchronous reset in the middle of a frame.
        cycle(1'b0, 1'b1, 1'b0);
        repeat (14) cycle(1'b1, 1'b0, 1'b0);
        bus.ivalid = 1'b1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_iready", 32'(bus.iready), 32'd0);
        chk("midrst_tap_en", 32'(bus.tap_en), 32'd0);
        chk("midrst_win_valid", 32'(bus.win_valid), 32'd0);
        model_reset();
        bus.ivalid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_frame(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
